// File: rtl/traffic_injector.sv
// traffic_injector: turns the per-router LFSR byte stream into wormhole packets
// (head/body/tail flits) and injects them into the local router port over a
// valid/ready handshake. The LFSR is advanced only when a value is consumed.
//
// Build option: define INJ_SEQNUM_EN to carry an 8-bit per-packet sequence
// number in the first flit after the head instead of an LFSR byte.
`timescale 1ns/1ps

module traffic_injector #(
    parameter logic [3:0]  LOCAL_ID = 4'd0,
    parameter int unsigned PKT_LEN  = 4,
    parameter int unsigned INJ_RATE = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  lfsr_in,
    output logic        lfsr_en,
    output logic        flit_valid,
    input  logic        flit_ready,
    output logic [9:0]  flit_data,
    output logic [15:0] pkt_count
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StSend = 1'b1;

    localparam logic [1:0] TypeBody     = 2'b00;
    localparam logic [1:0] TypeHead     = 2'b01;
    localparam logic [1:0] TypeTail     = 2'b10;
    localparam logic [1:0] TypeHeadTail = 2'b11;

    localparam logic [3:0] LastCnt    = 4'(PKT_LEN - 1);
    // One extra bit so INJ_RATE = 16 means "always below threshold".
    localparam logic [4:0] RateThresh = 5'(INJ_RATE);

    logic [0:0]  state_q, state_d;
    logic [3:0]  flit_cnt_q, flit_cnt_d;
    logic        flit_valid_q, flit_valid_d;
    logic [9:0]  flit_data_q, flit_data_d;
    logic [15:0] pkt_count_q, pkt_count_d;

    logic        xfer;
    logic        last_flit;
    logic        rate_ok;
    logic        dest_ok;
    logic        launch;
    logic        seq_slot;
    logic [7:0]  next_payload;
    logic        lfsr_adv;

`ifdef INJ_SEQNUM_EN
    logic [7:0]  seq_q, seq_d;
`endif

    // Handshake and launch decode.
    always_comb begin
        xfer      = flit_valid_q & flit_ready;
        last_flit = (flit_cnt_q == LastCnt);
        rate_ok   = ({1'b0, lfsr_in[7:4]} < RateThresh);
        dest_ok   = (lfsr_in[3:0] != LOCAL_ID);
        launch    = (state_q == StIdle) & enable & rate_ok & dest_ok;
`ifdef INJ_SEQNUM_EN
        // Loading the flit right after the head: it carries seq, not LFSR data.
        seq_slot     = (state_q == StSend) & (flit_cnt_q == 4'd0);
        next_payload = seq_slot ? seq_q : lfsr_in;
`else
        seq_slot     = 1'b0;
        next_payload = lfsr_in;
`endif
    end

    // Next-state, packet framing and LFSR advance request.
    always_comb begin
        state_d      = state_q;
        flit_cnt_d   = flit_cnt_q;
        flit_valid_d = flit_valid_q;
        flit_data_d  = flit_data_q;
        pkt_count_d  = pkt_count_q;
        lfsr_adv     = 1'b0;
`ifdef INJ_SEQNUM_EN
        seq_d        = seq_q;
`endif
        case (state_q)
            StIdle: begin
                // Every value seen while idle is consumed, launched or not.
                lfsr_adv = enable;
                if (launch) begin
                    state_d      = StSend;
                    flit_cnt_d   = 4'd0;
                    flit_valid_d = 1'b1;
                    flit_data_d  = {(LastCnt == 4'd0) ? TypeHeadTail : TypeHead,
                                    LOCAL_ID, lfsr_in[3:0]};
                end
            end
            StSend: begin
                if (xfer) begin
                    if (last_flit) begin
                        state_d      = StIdle;
                        flit_valid_d = 1'b0;
                        pkt_count_d  = pkt_count_q + 16'd1;
`ifdef INJ_SEQNUM_EN
                        seq_d        = seq_q + 8'd1;
`endif
                    end else begin
                        lfsr_adv    = ~seq_slot;
                        flit_cnt_d  = flit_cnt_q + 4'd1;
                        flit_data_d = {((flit_cnt_q + 4'd1) == LastCnt) ? TypeTail : TypeBody,
                                       next_payload};
                    end
                end
            end
            default: begin
                state_d      = StIdle;
                flit_valid_d = 1'b0;
            end
        endcase
    end

    // lfsr_en must stay low while reset is held, independent of state.
    assign lfsr_en    = lfsr_adv & reset;
    assign flit_valid = flit_valid_q;
    assign flit_data  = flit_data_q;
    assign pkt_count  = pkt_count_q;

    // State registers; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            flit_cnt_q   <= 4'd0;
            flit_valid_q <= 1'b0;
            flit_data_q  <= 10'd0;
            pkt_count_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            flit_cnt_q   <= flit_cnt_d;
            flit_valid_q <= flit_valid_d;
            flit_data_q  <= flit_data_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

`ifdef INJ_SEQNUM_EN
    // Per-packet sequence number, bumped on every tail transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_q <= 8'd0;
        end else begin
            seq_q <= seq_d;
        end
    end
`endif

`ifndef SYNTHESIS
    // A stalled flit must not change.
    a_stall_hold: assert property (@(posedge clk) disable iff (!reset)
        (flit_valid && !flit_ready) |=> (flit_valid && $stable(flit_data)));

    // Flit counter never runs past the packet length.
    a_cnt_range: assert property (@(posedge clk) disable iff (!reset)
        flit_cnt_q <= LastCnt);
`endif

endmodule

// File: tb/tb_traffic_injector.sv
`timescale 1ns/1ps

module tb_traffic_injector;

`ifdef INJ_SEQNUM_EN
    localparam bit SeqEn = 1'b1;
`else
    localparam bit SeqEn = 1'b0;
`endif

    localparam logic [3:0] IdB   = 4'd5;
    localparam int         LenB  = 4;
    localparam int         RateB = 4;
    localparam int         N     = 2000;
    localparam int         RndCycles = 1500;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        flit_ready = 1'b1;
    logic [7:0]  lfsr_in = 8'h3A;

    logic        lfsr_en_a, flit_valid_a;
    logic [9:0]  flit_data_a;
    logic [15:0] pkt_count_a;
    logic        lfsr_en_c, flit_valid_c;
    logic [9:0]  flit_data_c;
    logic [15:0] pkt_count_c;
    logic        lfsr_en_d, flit_valid_d;
    logic [9:0]  flit_data_d;
    logic [15:0] pkt_count_d;

    logic [7:0]  lfsr_b = 8'h4C;
    logic        ready_b = 1'b1;
    logic        lfsr_en_b, valid_b;
    logic [9:0]  data_b;
    logic [15:0] pkt_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit c_seen   = 1'b0;

    always #5 clk = ~clk;

    traffic_injector #(.LOCAL_ID(4'd5), .PKT_LEN(4), .INJ_RATE(16)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .lfsr_in(lfsr_in), .lfsr_en(lfsr_en_a),
        .flit_valid(flit_valid_a), .flit_ready(flit_ready), .flit_data(flit_data_a),
        .pkt_count(pkt_count_a));

    traffic_injector #(.LOCAL_ID(IdB), .PKT_LEN(LenB), .INJ_RATE(RateB)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .lfsr_in(lfsr_b), .lfsr_en(lfsr_en_b),
        .flit_valid(valid_b), .flit_ready(ready_b), .flit_data(data_b), .pkt_count(pkt_b));

    traffic_injector #(.LOCAL_ID(4'd5), .PKT_LEN(4), .INJ_RATE(0)) u_c (
        .clk(clk), .reset(reset), .enable(enable), .lfsr_in(lfsr_in), .lfsr_en(lfsr_en_c),
        .flit_valid(flit_valid_c), .flit_ready(flit_ready), .flit_data(flit_data_c),
        .pkt_count(pkt_count_c));

    traffic_injector #(.LOCAL_ID(4'd5), .PKT_LEN(1), .INJ_RATE(16)) u_d (
        .clk(clk), .reset(reset), .enable(enable), .lfsr_in(lfsr_in), .lfsr_en(lfsr_en_d),
        .flit_valid(flit_valid_d), .flit_ready(flit_ready), .flit_data(flit_data_d),
        .pkt_count(pkt_count_d));

    // The zero-rate injector must never present a flit.
    always @(negedge clk) begin
        if (reset && flit_valid_c) c_seen = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic        rdy;
        logic [7:0]  lfsr;
        logic        vld;
        logic        cd;
        logic [9:0]  data;
        logic        len;
        logic [15:0] pkt;
        logic        dv;
        logic [9:0]  dd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic rdy, input logic [7:0] lfsr,
                       input logic vld, input logic cd, input logic [9:0] data,
                       input logic len, input logic [15:0] pkt,
                       input logic dv, input logic [9:0] dd);
        vec_t v;
        v.en = en; v.rdy = rdy; v.lfsr = lfsr; v.vld = vld; v.cd = cd; v.data = data;
        v.len = len; v.pkt = pkt; v.dv = dv; v.dd = dd;
        vecs.push_back(v);
    endtask

    logic [7:0]  stream_b [N];
    logic [9:0]  exp_q[$];
    logic [15:0] exp_pkt;

    initial begin
        int          ptr_b;
        logic        en_b_s;
        logic        pv, pr;
        logic [9:0]  pd;
        logic [9:0]  e;

        // Cycle table for u_a (ID 5, 4 flits, rate 16) and u_d (ID 5, 1 flit).
        // Row: en, rdy, lfsr | a: valid, check-data, data, lfsr_en, pkt | d: valid, data
        add(1, 1, 8'h3A, 0, 1, 10'h000, 1, 0, 0, 10'h000);
        add(1, 1, 8'h11, 1, 1, 10'h15A, !SeqEn, 0, 1, 10'h35A);
        add(1, 1, 8'h22, 1, 1, SeqEn ? 10'h000 : 10'h011, 1, 0, 0, 10'h000);
        add(1, 1, 8'h33, 1, 1, 10'h022, 1, 0, 1, 10'h352);
        add(1, 1, 8'h05, 1, 1, 10'h233, 0, 0, 0, 10'h000);
        add(1, 1, 8'h05, 0, 0, 10'h000, 1, 1, 0, 10'h000);
        add(1, 1, 8'h05, 0, 0, 10'h000, 1, 1, 0, 10'h000);
        add(1, 0, 8'h3A, 0, 0, 10'h000, 1, 1, 0, 10'h000);
        add(1, 0, 8'h11, 1, 1, 10'h15A, 0, 1, 1, 10'h35A);
        add(1, 0, 8'h11, 1, 1, 10'h15A, 0, 1, 1, 10'h35A);
        add(1, 0, 8'h11, 1, 1, 10'h15A, 0, 1, 1, 10'h35A);
        add(1, 1, 8'h11, 1, 1, 10'h15A, !SeqEn, 1, 1, 10'h35A);
        add(0, 1, 8'h22, 1, 1, SeqEn ? 10'h001 : 10'h011, 1, 1, 0, 10'h000);
        add(0, 1, 8'h33, 1, 1, 10'h022, 1, 1, 0, 10'h000);
        add(0, 1, 8'h3A, 1, 1, 10'h233, 0, 1, 0, 10'h000);
        add(0, 1, 8'h3A, 0, 0, 10'h000, 0, 2, 0, 10'h000);
        add(0, 1, 8'h3A, 0, 0, 10'h000, 0, 2, 0, 10'h000);
        add(0, 1, 8'h3A, 0, 0, 10'h000, 0, 2, 0, 10'h000);

        // Reset held with a launchable value and enable high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset valid",   32'(flit_valid_a), 32'(0));
            chk("reset data",    32'(flit_data_a),  32'(0));
            chk("reset pkt",     32'(pkt_count_a),  32'(0));
            chk("reset lfsr_en", 32'(lfsr_en_a),    32'(0));
        end
        lfsr_in = 8'h05;
        #1 reset = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            enable     = vecs[i].en;
            flit_ready = vecs[i].rdy;
            lfsr_in    = vecs[i].lfsr;
            @(negedge clk);
            chk($sformatf("vec%0d valid", i), 32'(flit_valid_a), 32'(vecs[i].vld));
            if (vecs[i].cd)
                chk($sformatf("vec%0d data", i), 32'(flit_data_a), 32'(vecs[i].data));
            chk($sformatf("vec%0d lfsr_en", i), 32'(lfsr_en_a), 32'(vecs[i].len));
            chk($sformatf("vec%0d pkt", i), 32'(pkt_count_a), 32'(vecs[i].pkt));
            chk($sformatf("vec%0d d valid", i), 32'(flit_valid_d), 32'(vecs[i].dv));
            if (vecs[i].dv)
                chk($sformatf("vec%0d d data", i), 32'(flit_data_d), 32'(vecs[i].dd));
        end

        // Zero injection rate: values keep being consumed, nothing launches.
        enable = 1'b1;
        flit_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1 lfsr_in = 8'($urandom_range(0, 255));
            @(negedge clk);
            chk("rate0 lfsr_en", 32'(lfsr_en_c), 32'(1));
        end
        chk("rate0 pkt", 32'(pkt_count_c), 32'(0));
        chk("rate0 never valid", 32'(c_seen), 32'(0));

        // u_b, rate 4: 0x4C is rejected but still consumed; 0x3A launches.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rate reject valid",   32'(valid_b),   32'(0));
            chk("rate reject lfsr_en", 32'(lfsr_en_b), 32'(1));
        end
        lfsr_b = 8'h3A;
        @(posedge clk);
        #1 lfsr_b = 8'h4C;
        @(negedge clk);
        chk("rate accept valid", 32'(valid_b), 32'(1));
        chk("rate accept head",  32'(data_b),  32'(10'h15A));
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rate accept pkt", 32'(pkt_b), 32'(1));

        // Random stream for u_b with random backpressure, against a packet-level model.
        for (int i = 0; i < N; i++) stream_b[i] = 8'($urandom_range(0, 255));
        begin
            int         k;
            logic [7:0] mseq;
            logic [7:0] v;
            k = 0;
            mseq = 8'd1;  // one packet already sent above
            while (k < N) begin
                v = stream_b[k];
                k++;
                if ({1'b0, v[7:4]} < 5'(RateB) && v[3:0] != IdB) begin
                    exp_q.push_back({(LenB == 1) ? 2'b11 : 2'b01, IdB, v[3:0]});
                    for (int j = 1; j < LenB; j++) begin
                        logic [7:0] p;
                        if (SeqEn && j == 1) begin
                            p = mseq;
                        end else begin
                            if (k >= N) break;
                            p = stream_b[k];
                            k++;
                        end
                        exp_q.push_back({(j == LenB - 1) ? 2'b10 : 2'b00, p});
                    end
                    mseq++;
                end
            end
        end
        exp_pkt = 16'd1;
        ptr_b = 0;
        lfsr_b = stream_b[0];
        #1 en_b_s = lfsr_en_b;
        pv = 1'b0;
        pr = 1'b1;
        pd = 10'd0;
        for (int cyc = 0; cyc < RndCycles; cyc++) begin
            @(posedge clk);
            #1;
            if (en_b_s) ptr_b++;
            lfsr_b  = stream_b[ptr_b];
            ready_b = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            en_b_s = lfsr_en_b;
            if (pv && !pr) begin
                chk("rnd stall valid", 32'(valid_b), 32'(1));
                chk("rnd stall data",  32'(data_b),  32'(pd));
            end
            if (valid_b && !ready_b)
                chk("rnd stall lfsr_en", 32'(lfsr_en_b), 32'(0));
            if (valid_b && ready_b) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rnd xfer: got 0x%0h, expected no transfer", data_b);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd xfer", 32'(data_b), 32'(e));
                    if (e[9]) exp_pkt++;
                end
            end
            pv = valid_b;
            pr = ready_b;
            pd = data_b;
        end
        @(posedge clk);
        #1 ready_b = 1'b0;
        @(negedge clk);
        chk("rnd pkt_count", 32'(pkt_b), 32'(exp_pkt));

        // Asynchronous reset in the middle of a stalled packet.
        lfsr_in = 8'h05;
        flit_ready = 1'b1;
        enable = 1'b1;
        repeat (20) @(posedge clk);
        #1 begin
            lfsr_in = 8'h3A;
            flit_ready = 1'b0;
        end
        @(posedge clk);
        #1 lfsr_in = 8'h05;
        @(negedge clk);
        chk("pre-abort valid", 32'(flit_valid_a), 32'(1));
        chk("pre-abort head",  32'(flit_data_a),  32'(10'h15A));
        #2 reset = 1'b0;
        #1;
        chk("abort valid",   32'(flit_valid_a), 32'(0));
        chk("abort data",    32'(flit_data_a),  32'(0));
        chk("abort pkt",     32'(pkt_count_a),  32'(0));
        chk("abort lfsr_en", 32'(lfsr_en_a),    32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_injector.md
Name: traffic_injector

Overview:
- Downstream consumer of the per-router 8-bit LFSR traffic generator.
- Turns the pseudo-random byte stream into complete wormhole packets (head/body/tail flits).
- Injects the flits into the router's local input port over a valid/ready handshake.
- Controls injection rate, destination selection and packet framing, and advances the LFSR only when it consumes a value.

Parameters:
- LOCAL_ID, 4'd0: this router's node ID in the 4x4 mesh ({x[1:0],y[1:0]}).
- PKT_LEN, 4: flits per packet including head and tail; legal range 1..16.
- INJ_RATE, 8: injection threshold, 0..16. A packet is launched when lfsr_in[7:4] < INJ_RATE. 0 = never, 16 = every eligible cycle.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  permits launching new packets.
- lfsr_in  input  8  current LFSR value.
- lfsr_en  output  1  advance request to the LFSR (its enable input).
- flit_valid  output  1  flit_data holds a valid flit.
- flit_ready  input  1  router local port accepts the flit this cycle.
- flit_data  output  10  flit: [9:8] type, [7:0] payload.
- pkt_count  output  16  packets fully injected; wraps.

Behaviour:
- Reset (reset=0, async): state=IDLE, flit_cnt=0, flit_valid=0, flit_data=0, pkt_count=0. lfsr_en=0 while reset is low.
- Flit types: 01 head, 00 body, 10 tail, 11 head+tail (PKT_LEN=1 only).
- Head payload: {LOCAL_ID[3:0], dest[3:0]}.
- Body and tail payload: the lfsr_in value sampled when that flit is loaded.
- All outputs except lfsr_en are registered. lfsr_en is combinational from state, enable and the handshake.
- Handshake: transfer occurs when flit_valid && flit_ready. While flit_valid=1 and flit_ready=0, flit_data is held stable and lfsr_en=0.
- State IDLE:
  - lfsr_en = enable.
  - Launch condition: enable && lfsr_in[7:4] < INJ_RATE && lfsr_in[3:0] != LOCAL_ID.
  - On launch: dest = lfsr_in[3:0]. Next cycle flit_valid=1 with the head flit (type 11 if PKT_LEN=1), flit_cnt=0, state=SEND.
  - Self-addressed or rate-rejected values are discarded; the LFSR still advances.
- State SEND, on transfer with flit_cnt == PKT_LEN-1:
  - pkt_count increments (16'hFFFF wraps to 0).
  - flit_valid=0 next cycle; state=IDLE.
  - No launch can occur in the same cycle, so there is at least one idle cycle between packets.
- State SEND, on transfer with flit_cnt < PKT_LEN-1:
  - lfsr_en=1 that cycle.
  - Next flit loaded with payload lfsr_in; type tail if flit_cnt+1 == PKT_LEN-1, else body.
  - flit_cnt increments; flit_valid stays 1.
- enable deasserted during SEND: the current packet completes normally and no new packet launches. A packet is never truncated.
- Reset asserted mid-packet: immediate abort, flit_valid=0. Dropping the partial packet is accepted.
- flit_cnt is 4 bits and never exceeds PKT_LEN-1.

Optional Feature:
- Macro: INJ_SEQNUM_EN.
- Defined:
  - Adds an internal 8-bit seq register (reset 0).
  - The first flit after the head (body, or tail if PKT_LEN=2) carries seq instead of lfsr_in, and lfsr_en stays 0 on that load.
  - seq increments on each tail transfer and wraps 8'hFF to 0.
  - With PKT_LEN=1 there is no such flit; seq still increments per packet.
- Not defined: all payload flits use lfsr_in; no seq register exists.

Test Plan:
1. Reset: hold reset=0 with enable=1, lfsr_in=0x3A -> flit_valid=0, flit_data=10'h000, pkt_count=0, lfsr_en=0; outputs clear asynchronously mid-cycle.
2. LOCAL_ID=5, PKT_LEN=4, INJ_RATE=16, flit_ready=1, lfsr_in sequence 0x3A,0x11,0x22,0x33 -> flits 10'h15A, 10'h011, 10'h022, 10'h233 on consecutive cycles; pkt_count=1; flit_valid low for at least 1 cycle afterwards.
3. LOCAL_ID=5, lfsr_in=0x35 (self-addressed), enable=1 -> no head issued; lfsr_en=1 every cycle; lfsr_in=0x4C with INJ_RATE=4 -> rejected; INJ_RATE=0 for 100 cycles -> pkt_count stays 0.
4. Backpressure: flit_ready=0 for 3 cycles after head 10'h15A -> flit_data held at 10'h15A, lfsr_en=0 throughout; flit_ready=1 -> transfer, body loaded next cycle.
5. Drop enable in the cycle after the head transfer -> remaining body/tail flits still issued; pkt_count+1; no further head while enable=0.
6. PKT_LEN=1 -> single flit type 11 (e.g. 10'h35A); with INJ_SEQNUM_EN and PKT_LEN=4, first body payload = 0x00 for packet 0 and 0x01 for packet 1.
